hrt_share_scheduler: RTL and testbench

Sequences a single 32-bit high-resolution interval timer (16-bit Avalon-MM register slave, 3-bit address, IRQ output) on behalf of N hardware requesters. Requests for one-shot delays are arbitrated round-robin. The timer is programmed through its register port, the block waits for its IRQ, clears it and pulses `done` to the winner. It sits between requester logic and the timer slave, and it is the only master on that slave.

---
 rtl/hrt_share_scheduler.sv | 173 +++++++++++++++++
 tb/tb_hrt_share_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrt_share_scheduler.sv
// hrt_share_scheduler: round-robin arbiter that time-shares one interval timer among
// N one-shot delay requesters, programming it over its 16-bit Avalon-MM slave port.
module hrt_share_scheduler #(
    parameter int N  = 4,
    parameter int CW = 32    // at most 32: the timer period register is 32 bits
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*CW-1:0]      req_cycles,
    output logic [N-1:0]         done,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq
);
    localparam int IW = $clog2(N);

    localparam logic [2:0]  A_STATUS  = 3'd0;
    localparam logic [2:0]  A_CONTROL = 3'd1;
    localparam logic [2:0]  A_PER_LO  = 3'd2;
    localparam logic [2:0]  A_PER_HI  = 3'd3;
    localparam logic [15:0] CTL_START = 16'h0005;  // START | ITO, one-shot
    localparam logic [15:0] CTL_STOP  = 16'h0008;  // STOP, interrupt disabled

    typedef enum logic [2:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_CLR0, S_WR_CTL, S_WAIT, S_WR_STOP, S_WR_CLR
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [31:0]   period_q, period_d;
    logic [N-1:0]  done_q, done_d;
    logic          busy_q, busy_d;
    logic          cs_q, cs_d;
    logic          wr_n_q;
    logic [2:0]    addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [31:0]   raw_cycles;
    logic [31:0]   reload_val;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_valid && req[(int'(ptr_q) + k) % N]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    // The timer reloads with period+1 cycles; counts below 2 never produce a zero edge.
    always_comb begin
        raw_cycles         = '0;
        raw_cycles[CW-1:0] = req_cycles[int'(pick_idx)*CW +: CW];
        reload_val         = (raw_cycles < 32'd2) ? 32'd1 : raw_cycles - 32'd1;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        period_d = period_q;
        done_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d  = S_WR_PL;
                    grant_d  = pick_idx;
                    period_d = reload_val;
                    ptr_d    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            S_WR_PL:  state_d = S_WR_PH;
            S_WR_PH:  state_d = S_CLR0;
            S_CLR0:   state_d = S_WR_CTL;
            S_WR_CTL: state_d = S_WAIT;
            S_WAIT: begin
                // A timeout wins over a cancel seen in the same cycle.
                if (tmr_irq) begin
                    state_d         = S_WR_CLR;
                    done_d[grant_q] = 1'b1;
                end else if (!req[grant_q]) begin
                    state_d = S_WR_STOP;
                end
            end
            S_WR_STOP: state_d = S_WR_CLR;
            S_WR_CLR:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus cycle decoded from the next state so the registered outputs line up with it.
    always_comb begin
        cs_d    = 1'b0;
        addr_d  = A_STATUS;
        wdata_d = '0;
        unique case (state_d)
            S_WR_PL: begin
                cs_d    = 1'b1;
                addr_d  = A_PER_LO;
                wdata_d = period_d[15:0];
            end
            S_WR_PH: begin
                cs_d    = 1'b1;
                addr_d  = A_PER_HI;
                wdata_d = period_d[31:16];
            end
            S_CLR0, S_WR_CLR: begin
                cs_d    = 1'b1;
                addr_d  = A_STATUS;
            end
            S_WR_CTL: begin
                cs_d    = 1'b1;
                addr_d  = A_CONTROL;
                wdata_d = CTL_START;
            end
            S_WR_STOP: begin
                cs_d    = 1'b1;
                addr_d  = A_CONTROL;
                wdata_d = CTL_STOP;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            period_q <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cs_q     <= 1'b0;
            wr_n_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            period_q <= period_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cs_q     <= cs_d;
            wr_n_q   <= ~cs_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign done           = done_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wr_n_q;
    assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_hrt_share_scheduler.sv
// Bench for hrt_share_scheduler: interval-timer model, transaction-queue reference
// of expected bus cycles, directed scenarios and a randomized request phase.
module tb_hrt_share_scheduler;
    localparam int N  = 4;
    localparam int CW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*CW-1:0] req_cycles = '0;
    logic [N-1:0]  done;
    logic          busy;
    logic [IW-1:0] grant_id;
    logic [2:0]    tmr_address;
    logic          tmr_chipselect;
    logic          tmr_write_n;
    logic [15:0]   tmr_writedata;
    logic          tmr_irq;

    always #5 clk = ~clk;

    hrt_share_scheduler #(.N(N), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_cycles(req_cycles),
        .done(done), .busy(busy), .grant_id(grant_id),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_irq(tmr_irq)
    );

    // Interval timer: not reset by the scheduler's reset, so stale runs survive it.
    logic [31:0] t_period = '0, t_cnt = '0;
    logic        t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0;
    assign tmr_irq = t_to & t_ito;

    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito <= tmr_writedata[0];
                    if (tmr_writedata[3]) t_run <= 1'b0;
                    else if (tmr_writedata[2]) t_run <= 1'b1;
                end
                3'd2: begin
                    t_period[15:0] <= tmr_writedata;
                    t_cnt <= {t_period[31:16], tmr_writedata};
                    t_run <= 1'b0;
                end
                3'd3: begin
                    t_period[31:16] <= tmr_writedata;
                    t_cnt <= {tmr_writedata, t_period[15:0]};
                    t_run <= 1'b0;
                end
                default: ;
            endcase
        end else if (t_run) begin
            if (t_cnt == 32'd0) begin
                t_to  <= 1'b1;
                t_run <= 1'b0;
                t_cnt <= t_period;
            end else begin
                t_cnt <= t_cnt - 32'd1;
            end
        end
    end

    // Reference: the bus cycle expected now, plus a queue of cycles already committed.
    typedef struct packed {
        logic         wr;
        logic [2:0]   addr;
        logic [15:0]  data;
        logic [N-1:0] dn;
        logic         wt;
    } item_t;

    item_t cur = '0;
    item_t pend[$];
    int    m_gid = 0, m_ptr = 0;
    int    glog[$];

    int n_vec = 0, n_bad = 0;
    int cycle_no = 0;
    int ev_ctl = 0, ev_stop = 0, ev_clr = 0, ev_done = 0;
    int n_stop = 0, n_done = 0, n_busy = 0;
    logic [15:0] ev_lo = '0, ev_hi = '0;
    logic [N-1:0] done_seen = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [2:0] a, input logic [15:0] d);
        item_t it;
        it = '0;
        it.wr = 1'b1;
        it.addr = a;
        it.data = d;
        return it;
    endfunction

    function automatic logic [63:0] act_vec();
        return 64'({busy, done, grant_id, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata});
    endfunction

    task automatic tick_cmp();
        logic [IW-1:0] g;
        @(negedge clk);
        cycle_no++;
        g = IW'(m_gid);
        check($sformatf("cyc%0d outputs", cycle_no), act_vec(),
              64'({cur.wr | cur.wt, cur.dn, g, cur.wr, ~cur.wr, cur.addr, cur.data}));
        if (cur.wr && cur.addr == 3'd1 && cur.data == 16'h5) ev_ctl = cycle_no;
        if (cur.wr && cur.addr == 3'd1 && cur.data == 16'h8) begin ev_stop = cycle_no; n_stop++; end
        if (cur.wr && cur.addr == 3'd2) ev_lo = cur.data;
        if (cur.wr && cur.addr == 3'd3) ev_hi = cur.data;
        if (cur.wr && cur.addr == 3'd0) ev_clr = cycle_no;
        if (|cur.dn) begin ev_done = cycle_no; n_done++; end
        done_seen = done_seen | cur.dn;
        if (cur.wr | cur.wt) n_busy++;
    endtask

    // Advance the reference by one cycle using the inputs the DUT samples at the next edge.
    task automatic model_next();
        item_t nxt;
        int    g;
        logic [CW-1:0] c;
        logic [31:0]   v;
        nxt = '0;
        if (reset) begin
            pend.delete();
            m_ptr = 0;
            m_gid = 0;
        end else if (cur.wt) begin
            if (tmr_irq) begin
                nxt = mk(3'd0, 16'h0);
                nxt.dn[m_gid] = 1'b1;
            end else if (!req[m_gid]) begin
                nxt = mk(3'd1, 16'h8);
                pend.push_back(mk(3'd0, 16'h0));
            end else begin
                nxt.wt = 1'b1;
            end
        end else if (pend.size() > 0) begin
            nxt = pend.pop_front();
        end else if (!cur.wr && |req) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            c = req_cycles[g*CW +: CW];
            v = (c < 2) ? 32'd1 : 32'(c) - 32'd1;
            nxt = mk(3'd2, v[15:0]);
            pend.push_back(mk(3'd3, v[31:16]));
            pend.push_back(mk(3'd0, 16'h0));
            pend.push_back(mk(3'd1, 16'h5));
            pend.push_back('{wr: 1'b0, addr: 3'd0, data: 16'h0, dn: '0, wt: 1'b1});
            m_gid = g;
            m_ptr = (g + 1) % N;
            glog.push_back(g);
        end
        cur = nxt;
    endtask

    task automatic step();
        tick_cmp();
        for (int i = 0; i < N; i++) if (cur.dn[i]) req[i] = 1'b0;
        model_next();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic request(input int i, input logic [CW-1:0] c, output int t0);
        tick_cmp();
        req[i] = 1'b1;
        req_cycles[i*CW +: CW] = c;
        t0 = cycle_no;
        model_next();
    endtask

    task automatic run_until_done(input int i, input int budget);
        int n;
        n = 0;
        done_seen = '0;
        while (!done_seen[i] && n < budget) begin step(); n++; end
        if (!done_seen[i]) check($sformatf("timeout waiting done[%0d]", i), 64'd0, 64'd1);
    endtask

    task automatic reset_dut(input int n);
        for (int k = 0; k < n; k++) begin tick_cmp(); reset = 1'b1; model_next(); end
        tick_cmp();
        reset = 1'b0;
        model_next();
    endtask

    function automatic logic [CW-1:0] rnd_cycles();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return CW'(1);
        return CW'($urandom_range(2, 40));
    endfunction

    int t0, d_cyc, w_cyc, n0, s0, n;
    logic hit, stale_seen;

    initial begin
        // Reset state: only write_n high.
        tick_cmp();
        check("reset_outputs", act_vec(), 64'h0000_0000_0008_0000);
        model_next();
        reset_dut(1);

        // Single request, 100 cycles.
        n_busy = 0;
        n0 = n_done;
        request(0, 100, t0);
        run_until_done(0, 300);
        idle(3);
        check("single_ctl_cycle", 64'(ev_ctl - t0), 64'd4);
        check("single_done_cycle", 64'(ev_done - t0), 64'd106);
        check("single_per_lo", 64'(ev_lo), 64'd99);
        check("single_per_hi", 64'(ev_hi), 64'd0);
        check("single_busy_cycles", 64'(n_busy), 64'd106);
        check("single_done_pulses", 64'(n_done - n0), 64'd1);

        // Clamped counts 0 and 1.
        for (int c = 0; c < 2; c++) begin
            request(1, CW'(c), t0);
            run_until_done(1, 50);
            check($sformatf("clamp%0d_per_lo", c), 64'(ev_lo), 64'd1);
            check($sformatf("clamp%0d_done_vs_ctl", c), 64'(ev_done - ev_ctl), 64'd4);
        end

        // Large count: check programming, then cancel rather than wait 64K cycles.
        n0 = n_done;
        s0 = n_stop;
        request(3, 32'h0001_0000, t0);
        idle(8);
        check("large_per_lo", 64'(ev_lo), 64'hFFFF);
        check("large_per_hi", 64'(ev_hi), 64'h0);
        tick_cmp();
        req[3] = 1'b0;
        model_next();
        idle(4);
        check("large_cancel_stop", 64'(n_stop - s0), 64'd1);
        check("large_cancel_no_done", 64'(n_done - n0), 64'd0);

        // Round robin from a freshly reset pointer.
        reset_dut(1);
        tick_cmp();
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_cycles[i*CW +: CW] = CW'(3 + 2 * i);
        glog.delete();
        model_next();
        run_until_done(3, 200);
        check("rr_grant_count", 64'(glog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < glog.size()) check($sformatf("rr_grant%0d", i), 64'(glog[i]), 64'(i));
        tick_cmp();
        req[0] = 1'b1;
        req[2] = 1'b1;
        glog.delete();
        model_next();
        run_until_done(2, 200);
        check("rr_wrap_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);

        // Cancel ten cycles into WAIT.
        n0 = n_done;
        s0 = n_stop;
        request(1, 200, t0);
        w_cyc = -1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            tick_cmp();
            if (cur.wt && w_cyc < 0) w_cyc = cycle_no;
            if (cur.wt && cycle_no == w_cyc + 10) begin req[1] = 1'b0; d_cyc = cycle_no; hit = 1'b1; end
            model_next();
            n++;
        end
        check("cancel_reached", 64'(hit), 64'd1);
        idle(2);
        check("cancel_stop_cycle", 64'(ev_stop - d_cyc), 64'd1);
        check("cancel_clr_cycle", 64'(ev_clr - d_cyc), 64'd2);
        check("cancel_idle", 64'(cur.wr | cur.wt), 64'd0);
        check("cancel_no_done", 64'(n_done - n0), 64'd0);

        // Cancel and IRQ in the same WAIT cycle: completion wins.
        s0 = n_stop;
        request(1, 20, t0);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            tick_cmp();
            if (cur.wt && tmr_irq) begin req[1] = 1'b0; d_cyc = cycle_no; hit = 1'b1; end
            model_next();
            n++;
        end
        check("simul_reached", 64'(hit), 64'd1);
        step();
        check("simul_done_cycle", 64'(ev_done - d_cyc), 64'd1);
        check("simul_done_vs_ctl", 64'(ev_done - ev_ctl), 64'd22);
        check("simul_no_stop", 64'(n_stop - s0), 64'd0);
        idle(2);

        // Reset in WAIT with the timer still running, then a fresh request.
        request(0, 30, t0);
        n = 0;
        while (!cur.wt && n < 20) begin step(); n++; end
        idle(5);
        tick_cmp();
        reset = 1'b1;
        req = '0;
        model_next();
        tick_cmp();
        reset = 1'b0;
        model_next();
        stale_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tmr_irq) stale_seen = 1'b1;
        end
        check("stale_irq_present", 64'(stale_seen), 64'd1);
        request(2, 50, t0);
        run_until_done(2, 200);
        check("post_reset_per_lo", 64'(ev_lo), 64'd49);
        check("post_reset_done_vs_ctl", 64'(ev_done - ev_ctl), 64'd52);
        check("post_reset_done_cycle", 64'(ev_done - t0), 64'd56);
        idle(2);

        // Randomized requests, cancels, re-requests and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            tick_cmp();
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && cur.dn[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (req[i] && cur.wt && m_gid == i && $urandom_range(0, 59) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 14) == 0) begin
                    req[i] = 1'b1;
                    req_cycles[i*CW +: CW] = rnd_cycles();
                end
            end
            model_next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
